// File: rtl/i2c_master_engine.sv
// Bit/byte-level I2C master sequencer. Command strobes become quarter-bit SCL/SDA
// open-drain activity; received data, ACK status and a completion pulse are returned.
module i2c_master_engine #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_write,
  input  logic             cmd_read_ack,
  input  logic             cmd_read_nack,
  input  logic [7:0]       txdata,
  output logic [7:0]       rxdata,
  output logic             rx_ack,
  output logic             busy,
  output logic             bus_idle,
  output logic             done,
  input  logic             scl_i,
  output logic             scl_oe,
  input  logic             sda_i,
  output logic             sda_oe
);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAckBit, StStop, StDone} state_e;
  typedef enum logic [1:0] {OpWrite, OpReadAck, OpReadNack} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rxdata_q, rxdata_d;
  logic             ack_smp_q, ack_smp_d;
  logic             rx_ack_q, rx_ack_d;
  logic             bus_idle_q, bus_idle_d;
  logic             done_q, done_d;
  logic             scl_oe_q, sda_oe_q;
  logic             active, stall, accept;

  assign busy     = (state_q != StIdle) || done_q;
  assign accept   = !busy && (cmd_start || cmd_stop || cmd_write || cmd_read_ack || cmd_read_nack);
  assign active   = state_q inside {StStart, StBit, StAckBit, StStop};
  // A slave holding SCL low while we release it freezes the quarter counter.
  assign stall    = active && !scl_oe && !scl_i;
  assign rxdata   = rxdata_q;
  assign rx_ack   = rx_ack_q;
  assign bus_idle = bus_idle_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= OpWrite;
      qtr_q      <= 2'd0;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      tx_q       <= 8'h00;
      sh_q       <= 8'h00;
      rxdata_q   <= 8'h00;
      ack_smp_q  <= 1'b1;
      rx_ack_q   <= 1'b1;
      bus_idle_q <= 1'b1;
      done_q     <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      qtr_q      <= qtr_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      rxdata_q   <= rxdata_d;
      ack_smp_q  <= ack_smp_d;
      rx_ack_q   <= rx_ack_d;
      bus_idle_q <= bus_idle_d;
      done_q     <= done_d;
      scl_oe_q   <= scl_oe;
      sda_oe_q   <= sda_oe;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    qtr_d      = qtr_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    sh_d       = sh_q;
    rxdata_d   = rxdata_q;
    ack_smp_d  = ack_smp_q;
    rx_ack_d   = rx_ack_q;
    bus_idle_d = bus_idle_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          qtr_d = 2'd0;
          cnt_d = clk_div;
          bit_d = 3'd7;
          tx_d  = txdata;
          if (cmd_start) begin
            state_d    = StStart;
            bus_idle_d = 1'b0;
          end else if (cmd_stop) begin
            state_d = StStop;
          end else begin
            state_d = StBit;
            op_d    = cmd_write ? OpWrite : (cmd_read_ack ? OpReadAck : OpReadNack);
          end
        end
      end
      StStart, StBit, StAckBit, StStop: begin
        if (!stall) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = clk_div;
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd2) begin
              if (state_q == StBit) sh_d = {sh_q[6:0], sda_i};
              if (state_q == StAckBit) ack_smp_d = sda_i;
            end
            if (qtr_q == 2'd3) begin
              unique case (state_q)
                StBit: begin
                  if (bit_q == 3'd0) state_d = StAckBit;
                  else bit_d = bit_q - 3'd1;
                end
                StAckBit: begin
                  state_d = StDone;
                  if (op_q == OpWrite) rx_ack_d = ack_smp_q;
                  else rxdata_d = sh_q;
                end
                StStop: begin
                  state_d    = StDone;
                  bus_idle_d = 1'b1;
                end
                default: state_d = StDone;
              endcase
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Lines hold their last value unless the current quarter defines them.
  always_comb begin
    scl_oe = scl_oe_q;
    sda_oe = sda_oe_q;
    unique case (state_q)
      StStart: begin
        unique case (qtr_q)
          2'd0: sda_oe = 1'b0;
          2'd1: begin scl_oe = 1'b0; sda_oe = 1'b0; end
          2'd2: begin scl_oe = 1'b0; sda_oe = 1'b1; end
          default: begin scl_oe = 1'b1; sda_oe = 1'b1; end
        endcase
      end
      StBit: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = (op_q == OpWrite) ? ~tx_q[bit_q] : 1'b0;
      end
      StAckBit: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = (op_q == OpReadAck);
      end
      StStop: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q == 2'd0) || (qtr_q == 2'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Bench for i2c_master_engine: a quarter-table line model plus a bus-level slave,
// driven by directed and random command sequences.
module tb_i2c_master_engine;
  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] clk_div = '0;
  logic             cmd_start = 1'b0, cmd_stop = 1'b0, cmd_write = 1'b0;
  logic             cmd_read_ack = 1'b0, cmd_read_nack = 1'b0;
  logic [7:0]       txdata = 8'h00;
  logic [7:0]       rxdata;
  logic             rx_ack, busy, bus_idle, done, scl_i, scl_oe, sda_i, sda_oe;
  logic             slave_pull = 1'b0, stall_next = 1'b0;

  always #5 clk = ~clk;
  assign scl_i = !scl_oe && !stall_next;
  assign sda_i = !(sda_oe || slave_pull);

  i2c_master_engine #(.DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .clk_div(clk_div),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_write(cmd_write),
    .cmd_read_ack(cmd_read_ack), .cmd_read_nack(cmd_read_nack),
    .txdata(txdata), .rxdata(rxdata), .rx_ack(rx_ack), .busy(busy),
    .bus_idle(bus_idle), .done(done), .scl_i(scl_i), .scl_oe(scl_oe),
    .sda_i(sda_i), .sda_oe(sda_oe)
  );

  typedef struct packed {logic scl; logic sda; logic qtr; logic dn;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int tests = 0, fails = 0;
  logic       m_scl = 1'b0, m_sda = 1'b0, m_rx_ack = 1'b1, m_bus_idle = 1'b1;
  logic [7:0] m_rxdata = 8'h00;
  logic       p_rx_ack, p_bus_idle;
  logic [7:0] p_rxdata;
  int         kind_cur = 0, sl_idx = 0;
  logic [7:0] sl_byte = 8'h00;
  logic       sl_ack = 1'b0;
  logic       prev_scl_oe = 1'b0, prev_sda_bus = 1'b1, last_sda = 1'b1, sda_bus;
  logic [7:0] mon_byte = 8'h00;
  int         start_seen = 0, stop_seen = 0, done_cnt = 0;
  int         cyc = 0, acc_cyc = 0, done_cyc = 0, str_left = 0;
  logic       str_arm = 1'b0, str_started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic scl, input logic sda, input int n, input logic q);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x = '{scl: scl, sda: sda, qtr: q, dn: 1'b0};
      exp_q.push_back(x);
    end
  endtask

  // Expected line waveform of one command: four quarters per bit, clk_div+1 cycles each.
  task automatic model_accept(input int kind);
    int n;
    logic sd;
    exp_t x;
    n = int'(clk_div) + 1;
    p_rxdata = m_rxdata; p_rx_ack = m_rx_ack; p_bus_idle = m_bus_idle;
    case (kind)
      1: begin
        push(m_scl, 1'b0, n, 1'b1); push(1'b0, 1'b0, n, 1'b1);
        push(1'b0, 1'b1, n, 1'b1); push(1'b1, 1'b1, n, 1'b1);
        p_bus_idle = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
      end
      2: begin
        push(1'b1, 1'b1, n, 1'b1); push(1'b0, 1'b1, n, 1'b1);
        push(1'b0, 1'b0, n, 1'b1); push(1'b0, 1'b0, n, 1'b1);
        p_bus_idle = 1'b1; m_scl = 1'b0; m_sda = 1'b0;
      end
      default: begin
        for (int i = 0; i < 9; i++) begin
          if (i == 8) sd = (kind == 4);
          else sd = (kind == 3) ? !txdata[7-i] : 1'b0;
          push(1'b1, sd, n, 1'b1); push(1'b0, sd, n, 1'b1);
          push(1'b0, sd, n, 1'b1); push(1'b1, sd, n, 1'b1);
          m_sda = sd;
        end
        m_scl = 1'b1;
        if (kind == 3) p_rx_ack = !sl_ack;
        else p_rxdata = sl_byte;
      end
    endcase
    push(m_scl, m_sda, 1, 1'b0);
    x = '{scl: m_scl, sda: m_sda, qtr: 1'b0, dn: 1'b1};
    exp_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (!reset_n) begin
        exp_q.delete();
        m_scl = 1'b0; m_sda = 1'b0; m_rx_ack = 1'b1; m_bus_idle = 1'b1; m_rxdata = 8'h00;
        kind_cur = 0; slave_pull = 1'b0; stall_next = 1'b0; str_left = 0;
        prev_scl_oe = 1'b0; prev_sda_bus = 1'b1;
        chk("rst_scl_oe", scl_oe, 0); chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_rxdata", rxdata, 8'h00); chk("rst_rx_ack", rx_ack, 1);
        chk("rst_bus_idle", bus_idle, 1);
      end else begin
        sda_bus = !(sda_oe || slave_pull);
        if (kind_cur >= 3) begin
          if (!scl_oe) last_sda = sda_bus;
          if (scl_oe && !prev_scl_oe) begin
            if (sl_idx < 8) mon_byte = {mon_byte[6:0], last_sda};
            sl_idx++;
          end
        end
        if (!scl_oe && !prev_scl_oe) begin
          if (prev_sda_bus && !sda_bus) start_seen++;
          if (!prev_sda_bus && sda_bus) stop_seen++;
        end
        prev_scl_oe = scl_oe;
        prev_sda_bus = sda_bus;
        if (str_arm && !str_started && kind_cur == 3 && sl_idx == 3 && !scl_oe) begin
          str_left = 10;
          str_started = 1'b1;
        end
        stall_next = (str_left > 0);
        if (stall_next) str_left--;
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("scl_oe", scl_oe, e.scl); chk("sda_oe", sda_oe, e.sda);
          chk("busy", busy, 1); chk("done", done, e.dn);
          if (e.dn) begin
            done_cyc = cyc;
            m_rxdata = p_rxdata; m_rx_ack = p_rx_ack; m_bus_idle = p_bus_idle;
            kind_cur = 0;
          end
          if (!(e.qtr && !e.scl && stall_next)) exp_q.delete(0);
        end else begin
          chk("idle_busy", busy, 0); chk("idle_done", done, 0);
          chk("idle_scl_oe", scl_oe, m_scl); chk("idle_sda_oe", sda_oe, m_sda);
          chk("rxdata", rxdata, m_rxdata); chk("rx_ack", rx_ack, m_rx_ack);
          chk("bus_idle", bus_idle, m_bus_idle);
          if (cmd_start || cmd_stop || cmd_write || cmd_read_ack || cmd_read_nack) begin
            kind_cur = cmd_start ? 1 : cmd_stop ? 2 : cmd_write ? 3 : cmd_read_ack ? 4 : 5;
            acc_cyc = cyc; sl_idx = 0; prev_scl_oe = 1'b1; mon_byte = 8'h00;
            str_started = 1'b0;
            model_accept(kind_cur);
          end
        end
        slave_pull = 1'b0;
        if ((kind_cur == 4 || kind_cur == 5) && sl_idx < 8) slave_pull = !sl_byte[7-sl_idx];
        else if (kind_cur == 3 && sl_idx == 8) slave_pull = sl_ack;
      end
    end
  end

  // Strobe order: {start, stop, write, read_ack, read_nack}.
  task automatic issue(input logic [4:0] m);
    @(posedge clk); #1;
    {cmd_start, cmd_stop, cmd_write, cmd_read_ack, cmd_read_nack} = m;
    @(posedge clk); #1;
    {cmd_start, cmd_stop, cmd_write, cmd_read_ack, cmd_read_nack} = 5'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    do begin @(posedge clk); #1; b++; end while ((busy || exp_q.size() != 0) && b < 5000);
    if (b >= 5000) begin
      tests++; fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", b);
    end
  endtask

  task automatic run(input logic [4:0] m);
    issue(m);
    wait_idle();
  endtask

  initial begin
    int dc, b;
    logic [4:0] m;
    #23 reset_n = 1'b1;
    clk_div = 16'd3;
    run(5'b10000);
    chk("lat_start_d3", done_cyc - acc_cyc - 1, 17);
    chk("start_seen", start_seen, 1);
    chk("bus_idle_after_start", bus_idle, 0);
    txdata = 8'hA5; sl_ack = 1'b1;
    run(5'b00100);
    chk("sampled_bits", mon_byte, 8'hA5);
    chk("rx_ack_0", rx_ack, 0);
    chk("lat_write_d3", done_cyc - acc_cyc - 1, 145);
    chk("bus_idle_mid", bus_idle, 0);
    clk_div = 16'd1; sl_byte = 8'h3C;
    run(5'b00001);
    chk("rxdata_3c", rxdata, 8'h3C);
    chk("lat_read_d1", done_cyc - acc_cyc - 1, 73);
    chk("nack_sda_rel", sda_oe, 0);
    run(5'b01000);
    chk("stop_seen", stop_seen, 1);
    chk("bus_idle_stop", bus_idle, 1);
    clk_div = 16'd0; sl_byte = 8'hFF;
    run(5'b10000);
    run(5'b00010);
    chk("rxdata_ff", rxdata, 8'hFF);
    chk("ack_sda_held", sda_oe, 1);
    chk("lat_read_d0", done_cyc - acc_cyc - 1, 37);
    run(5'b01000);
    clk_div = 16'd2; txdata = 8'h96; sl_ack = 1'b0;
    run(5'b10000);
    run(5'b00100);
    chk("lat_write_d2", done_cyc - acc_cyc - 1, 109);
    chk("rx_ack_nack", rx_ack, 1);
    str_arm = 1'b1; sl_ack = 1'b1;
    run(5'b00100);
    str_arm = 1'b0;
    chk("lat_stretch", done_cyc - acc_cyc - 1, 119);
    dc = done_cnt;
    issue(5'b00100);
    repeat (3) @(posedge clk);
    issue(5'b00100);
    wait_idle();
    chk("busy_strobe_ignored", done_cnt - dc, 1);
    run(5'b01000);
    dc = done_cnt; b = start_seen;
    run(5'b11000);
    chk("start_stop_single_done", done_cnt - dc, 1);
    chk("start_wins", start_seen - b, 1);
    chk("bus_idle_start_wins", bus_idle, 0);
    for (int i = 0; i < 40; i++) begin
      clk_div = 16'($urandom_range(0, 3));
      txdata = 8'($urandom); sl_byte = 8'($urandom); sl_ack = 1'($urandom);
      m = 5'($urandom_range(1, 31));
      str_arm = (m[4:2] == 3'b001) && ($urandom_range(0, 3) == 0);
      issue(m);
      if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(1, 31)));
      wait_idle();
      str_arm = 1'b0;
    end
    clk_div = 16'd3; txdata = 8'h5A;
    run(5'b10000);
    issue(5'b00100);
    repeat (10) @(posedge clk);
    b = 0;
    while (!scl_oe && b < 50) begin @(posedge clk); #1; b++; end
    chk("pre_reset_scl_oe", scl_oe, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_scl_oe", scl_oe, 0); chk("async_rst_sda_oe", sda_oe, 0);
    chk("async_rst_busy", busy, 0); chk("async_rst_rxdata", rxdata, 8'h00);
    chk("async_rst_rx_ack", rx_ack, 1); chk("async_rst_bus_idle", bus_idle, 1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run(5'b10000);
    chk("lat_start_after_rst", done_cyc - acc_cyc - 1, 17);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
